// File: rtl/aes128_key_sched_ctrl.sv
// AES-128 round-key scheduler: drives the key-expansion unit through rounds 1..10 and
// serves RK0..RK10 from an internal buffer. Define AES_KEYSCHED_ZEROIZE_EN to add the zeroize wipe input.
module aes128_key_sched_ctrl (
  input  logic         clk,
  input  logic         g_rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         keys_ready,
  output logic         kx_enable,
  output logic [3:0]   kx_round,
  output logic [127:0] kx_key_in,
  input  logic [127:0] kx_key_out,
  input  logic         rk_rd,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         rk_valid,
  output logic         rk_err
`ifdef AES_KEYSCHED_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          busy_q, busy_d;
  logic          keys_ready_q, keys_ready_d;
  logic [127:0]  buf_q [11];
  logic [127:0]  buf_d [11];
  logic [127:0]  rk_data_q, rk_data_d;
  logic          rk_valid_q, rk_valid_d;
  logic          rk_err_q, rk_err_d;
  logic          zeroize_s;

`ifdef AES_KEYSCHED_ZEROIZE_EN
  assign zeroize_s = zeroize;
`else
  assign zeroize_s = 1'b0;
`endif

  // Next-state, buffer-write and read-port logic
  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    busy_d       = busy_q;
    keys_ready_d = keys_ready_q;
    buf_d        = buf_q;
    rk_data_d    = rk_data_q;
    rk_valid_d   = 1'b0;
    rk_err_d     = 1'b0;

    if (zeroize_s) begin
      // Wipe wins over everything, including a read issued in the same cycle
      for (int i = 0; i < 11; i++) begin
        buf_d[i] = 128'd0;
      end
      state_d      = ST_IDLE;
      rnd_d        = 4'd0;
      busy_d       = 1'b0;
      keys_ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (key_load) begin
            buf_d[0]     = key_in;
            rnd_d        = 4'd1;
            state_d      = ST_EXPAND;
            busy_d       = 1'b1;
            keys_ready_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        ST_EXPAND: begin
          if (rnd_q == 4'd11) begin
            buf_d[10]    = kx_key_out;
            state_d      = ST_READY;
            busy_d       = 1'b0;
            keys_ready_d = 1'b1;
            rnd_d        = 4'd0;
          end else if ((rnd_q >= 4'd1) && (rnd_q <= 4'd10)) begin
            // Expansion result lags one cycle, so round r stores RK(r-1)
            if (rnd_q >= 4'd2) begin
              buf_d[rnd_q - 4'd1] = kx_key_out;
            end else begin
              buf_d[0] = buf_q[0];
            end
            rnd_d = rnd_q + 4'd1;
          end else begin
            state_d      = ST_IDLE;
            busy_d       = 1'b0;
            keys_ready_d = 1'b0;
            rnd_d        = 4'd0;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          keys_ready_d = 1'b0;
          rnd_d        = 4'd0;
        end
      endcase

      if (rk_rd) begin
        if ((state_q == ST_READY) && (rk_addr <= 4'd10)) begin
          rk_data_d  = buf_q[rk_addr];
          rk_valid_d = 1'b1;
        end else begin
          rk_data_d = 128'd0;
          rk_err_d  = 1'b1;
        end
      end else begin
        rk_data_d = rk_data_q;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      state_q      <= ST_IDLE;
      rnd_q        <= 4'd0;
      busy_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      rk_data_q    <= 128'd0;
      rk_valid_q   <= 1'b0;
      rk_err_q     <= 1'b0;
      for (int i = 0; i < 11; i++) begin
        buf_q[i] <= 128'd0;
      end
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      busy_q       <= busy_d;
      keys_ready_q <= keys_ready_d;
      rk_data_q    <= rk_data_d;
      rk_valid_q   <= rk_valid_d;
      rk_err_q     <= rk_err_d;
      for (int i = 0; i < 11; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Expansion-unit controls decode from state and round only, never from key_load
  always_comb begin
    kx_enable = 1'b0;
    kx_round  = 4'd0;
    kx_key_in = kx_key_out;
    if ((state_q == ST_EXPAND) && (rnd_q >= 4'd1) && (rnd_q <= 4'd10)) begin
      kx_enable = 1'b1;
      kx_round  = rnd_q;
      if (rnd_q == 4'd1) begin
        kx_key_in = buf_q[0];
      end else begin
        kx_key_in = kx_key_out;
      end
    end else begin
      kx_enable = 1'b0;
    end
  end

  assign busy       = busy_q;
  assign keys_ready = keys_ready_q;
  assign rk_data    = rk_data_q;
  assign rk_valid   = rk_valid_q;
  assign rk_err     = rk_err_q;

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Directed bench for aes128_key_sched_ctrl with a behavioural AES-128 key-expansion unit attached.
module tb_aes128_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         g_rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         busy, keys_ready, kx_enable;
  logic [3:0]   kx_round;
  logic [127:0] kx_key_in, kx_key_out;
  logic         rk_rd;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         rk_valid, rk_err;
`ifdef AES_KEYSCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK3 = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] FIPS_RK4 = 128'hef44a541a8525b7fb671253bdb0bad00;
  localparam logic [127:0] FIPS_RK5 = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [7:0] sbox [256];

  aes128_key_sched_ctrl dut (
    .clk        (clk),
    .g_rst      (g_rst),
    .key_load   (key_load),
    .key_in     (key_in),
    .busy       (busy),
    .keys_ready (keys_ready),
    .kx_enable  (kx_enable),
    .kx_round   (kx_round),
    .kx_key_in  (kx_key_in),
    .kx_key_out (kx_key_out),
    .rk_rd      (rk_rd),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data),
    .rk_valid   (rk_valid),
    .rk_err     (rk_err)
`ifdef AES_KEYSCHED_ZEROIZE_EN
    ,
    .zeroize    (zeroize)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] kx_expand(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox[rot[31:24]], sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]};
    n0 = w0 ^ sub ^ {rcon(r), 24'h000000};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Registered single-round expansion unit
  always @(posedge clk or posedge g_rst) begin
    if (g_rst) kx_key_out <= 128'd0;
    else if (kx_enable) kx_key_out <= kx_expand(kx_key_in, kx_round);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a);
    rk_addr = a;
    rk_rd   = 1'b1;
    cyc();
    rk_rd   = 1'b0;
  endtask

  task automatic run_load(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    cyc();
    key_load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (keys_ready) break;
      cyc();
    end
    check_eq("ready_timeout", keys_ready, 1'b1);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] y;
      y = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gmul(x[7:0], c[7:0]) == 8'h01) y = c[7:0];
      end
      sbox[x] = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    end

    g_rst = 1'b1; key_load = 1'b0; key_in = 128'd0; rk_rd = 1'b0; rk_addr = 4'd0;
`ifdef AES_KEYSCHED_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    cyc(); cyc();
    g_rst = 1'b0;
    cyc();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", keys_ready, 1'b0);
    check_eq("rst_kx_en", kx_enable, 1'b0);
    check_eq("rst_kx_round", kx_round, 4'd0);
    check_eq("rst_rk_data", rk_data, 128'd0);

    do_read(4'd0);
    check_eq("idle_rd_err", rk_err, 1'b1);
    check_eq("idle_rd_valid", rk_valid, 1'b0);
    check_eq("idle_rd_data", rk_data, 128'd0);
    check_eq("idle_ready", keys_ready, 1'b0);

    // FIPS load, watching the round sequence; a reload and a read land mid-expansion
    key_in = FIPS_KEY; key_load = 1'b1;
    cyc();
    key_load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check_eq($sformatf("exp_kx_en_%0d", k), kx_enable, 1'b1);
      check_eq($sformatf("exp_kx_round_%0d", k), kx_round, k[3:0]);
      check_eq($sformatf("exp_busy_%0d", k), busy, 1'b1);
      if (k == 5) begin
        check_eq("exp_rd_err", rk_err, 1'b1);
        check_eq("exp_rd_valid", rk_valid, 1'b0);
      end
      if (k == 4) begin
        key_in = 128'hffeeddccbbaa99887766554433221100; key_load = 1'b1;
        rk_rd = 1'b1; rk_addr = 4'd0;
      end else begin
        key_load = 1'b0; rk_rd = 1'b0;
      end
      cyc();
    end
    check_eq("rnd11_kx_en", kx_enable, 1'b0);
    check_eq("rnd11_busy", busy, 1'b1);
    check_eq("rnd11_ready", keys_ready, 1'b0);
    cyc();
    check_eq("lat12_ready", keys_ready, 1'b1);
    check_eq("lat12_busy", busy, 1'b0);

    do_read(4'd1);
    check_eq("rd1_valid", rk_valid, 1'b1);
    check_eq("rd1_data", rk_data, FIPS_RK1);
    do_read(4'd10);
    check_eq("rd10_data", rk_data, FIPS_RK10);
    do_read(4'd0);
    check_eq("rd0_data", rk_data, FIPS_KEY);
    do_read(4'd11);
    check_eq("rd11_err", rk_err, 1'b1);
    check_eq("rd11_valid", rk_valid, 1'b0);
    check_eq("rd11_data", rk_data, 128'd0);
    do_read(4'd15);
    check_eq("rd15_err", rk_err, 1'b1);

    rk_rd = 1'b1; rk_addr = 4'd3;
    cyc();
    check_eq("b2b3_valid", rk_valid, 1'b1);
    check_eq("b2b3_data", rk_data, FIPS_RK3);
    rk_addr = 4'd4;
    cyc();
    check_eq("b2b4_valid", rk_valid, 1'b1);
    check_eq("b2b4_data", rk_data, FIPS_RK4);
    rk_addr = 4'd5;
    cyc();
    check_eq("b2b5_valid", rk_valid, 1'b1);
    check_eq("b2b5_data", rk_data, FIPS_RK5);
    rk_rd = 1'b0;
    cyc();
    check_eq("idle_valid", rk_valid, 1'b0);
    check_eq("hold_data", rk_data, FIPS_RK5);

    // Load and read together, then reset in the middle of that expansion
    key_in = 128'd0; key_load = 1'b1; rk_rd = 1'b1; rk_addr = 4'd10;
    cyc();
    key_load = 1'b0; rk_rd = 1'b0;
    check_eq("ldrd_data", rk_data, FIPS_RK10);
    check_eq("ldrd_valid", rk_valid, 1'b1);
    check_eq("ldrd_ready", keys_ready, 1'b0);
    repeat (5) cyc();
    check_eq("pre_rst_round", kx_round, 4'd6);
    g_rst = 1'b1;
    #1;
    check_eq("async_rst_busy", busy, 1'b0);
    check_eq("async_rst_kx_en", kx_enable, 1'b0);
    check_eq("async_rst_ready", keys_ready, 1'b0);
    cyc();
    g_rst = 1'b0;
    cyc();
    check_eq("post_rst_ready", keys_ready, 1'b0);
    run_load(FIPS_KEY);
    do_read(4'd10);
    check_eq("reload_rd10", rk_data, FIPS_RK10);
    do_read(4'd1);
    check_eq("reload_rd1", rk_data, FIPS_RK1);

`ifdef AES_KEYSCHED_ZEROIZE_EN
    zeroize = 1'b1; rk_rd = 1'b1; rk_addr = 4'd1;
    cyc();
    zeroize = 1'b0; rk_rd = 1'b0;
    check_eq("zr_ready", keys_ready, 1'b0);
    check_eq("zr_valid", rk_valid, 1'b0);
    check_eq("zr_err", rk_err, 1'b0);
    run_load(128'd0);
    do_read(4'd1);
    check_eq("zr_new_rd1", rk_data, ZERO_RK1);
    do_read(4'd10);
    check_eq("zr_new_rd10", rk_data, ZERO_RK10);
    key_in = FIPS_KEY; key_load = 1'b1;
    cyc();
    key_load = 1'b0;
    repeat (3) cyc();
    zeroize = 1'b1;
    cyc();
    zeroize = 1'b0;
    check_eq("zx_busy", busy, 1'b0);
    check_eq("zx_kx_en", kx_enable, 1'b0);
    check_eq("zx_ready", keys_ready, 1'b0);
    do_read(4'd0);
    check_eq("zx_rd_err", rk_err, 1'b1);
`else
    run_load(128'd0);
    do_read(4'd1);
    check_eq("zero_rd1", rk_data, ZERO_RK1);
    do_read(4'd10);
    check_eq("zero_rd10", rk_data, ZERO_RK10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
